trace_packer: RTL

//  Upstream feeder of the trace logger. Samples the traced signal bus each qualified cycle,

---
 rtl/trace_packer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/trace_packer.sv
// Trace packer: samples the traced bus into 2**ntrace lanes per memory word and emits each
// completed word with a one-cycle store strobe; tracks the first trigger and stops on the delayed trigger.
module trace_packer #(
  parameter int TRB_WIDTH       = 64,
  parameter int TRB_NTRACE_BITS = 3
) (
  input  logic                         CLK_I,
  input  logic                         RST_NI,
  input  logic                         ENABLE_I,
  input  logic                         MODE_I,
  input  logic [TRB_NTRACE_BITS-1:0]   NTRACE_I,
  input  logic [TRB_WIDTH-1:0]         TRACE_I,
  input  logic                         TRACE_VALID_I,
  input  logic                         TRG_I,
  input  logic                         STORE_PERM_I,
  input  logic                         TRG_DELAYED_I,
  output logic [TRB_WIDTH-1:0]         DATA_O,
  output logic                         STORE_O,
  output logic                         TRG_EVENT_O,
  output logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_O,
  output logic                         OVERFLOW_O,
  output logic                         BUSY_O
);

  localparam int LOG2W  = $clog2(TRB_WIDTH);
  localparam int SLOT_W = (LOG2W > 0) ? LOG2W : 1;
  localparam logic [TRB_NTRACE_BITS-1:0] NTRACE_MAX = TRB_NTRACE_BITS'(LOG2W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic                         enable_q, enable_d;
  logic [TRB_NTRACE_BITS-1:0]   ntrace_q, ntrace_d;
  logic                         mode_q, mode_d;
  logic [SLOT_W-1:0]            slot_q, slot_d;
  logic [TRB_WIDTH-1:0]         pack_q, pack_d;
  logic [TRB_WIDTH-1:0]         data_q, data_d;
  logic                         store_q, store_d;
  logic                         trg_event_q, trg_event_d;
  logic [LOG2W-1:0]             event_pos_q, event_pos_d;
  logic                         overflow_q, overflow_d;

  logic                         rise_s;
  logic                         arm_s;
  logic                         sample_s;
  logic                         last_s;
  logic [TRB_NTRACE_BITS-1:0]   ntrace_in_s;
  logic [TRB_NTRACE_BITS-1:0]   lsh_s;
  logic [LOG2W:0]               w_s;
  logic [TRB_WIDTH-1:0]         mask_s;
  logic [SLOT_W-1:0]            off_s;
  logic [SLOT_W-1:0]            slot_max_s;
  logic [TRB_WIDTH-1:0]         word_s;

  // Lane geometry: offset of the current slot is slot << (log2(TRB_WIDTH) - ntrace)
  always_comb begin
    rise_s      = ENABLE_I & ~enable_q;
    arm_s       = rise_s & (state_q == ST_IDLE);
    sample_s    = ENABLE_I & TRACE_VALID_I & ((state_q == ST_ARMED) | (state_q == ST_TRIG));
    ntrace_in_s = (NTRACE_I > NTRACE_MAX) ? NTRACE_MAX : NTRACE_I;
    lsh_s       = NTRACE_MAX - ntrace_q;
    w_s         = (LOG2W + 1)'(TRB_WIDTH) >> ntrace_q;
    mask_s      = ~({TRB_WIDTH{1'b1}} << w_s);
    off_s       = slot_q << lsh_s;
    slot_max_s  = {SLOT_W{1'b1}} >> lsh_s;
    last_s      = (slot_q == slot_max_s);
    word_s      = (pack_q & ~(mask_s << off_s)) | ((TRACE_I & mask_s) << off_s);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) state_d = ST_ARMED;
        else        state_d = ST_IDLE;
      end
      ST_ARMED: begin
        if (!ENABLE_I)                            state_d = ST_IDLE;
        else if (sample_s && TRG_I && !mode_q)    state_d = ST_TRIG;
        else                                      state_d = ST_ARMED;
      end
      ST_TRIG: begin
        if (!ENABLE_I)          state_d = ST_IDLE;
        else if (TRG_DELAYED_I) state_d = ST_STOP;
        else                    state_d = ST_TRIG;
      end
      ST_STOP: begin
        if (!ENABLE_I) state_d = ST_IDLE;
        else           state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    case (state_q)
      ST_ARMED: BUSY_O = 1'b1;
      ST_TRIG:  BUSY_O = 1'b1;
      default:  BUSY_O = 1'b0;
    endcase
  end

  // Datapath next values: config latch, lane packing, store, trigger and overflow tracking
  always_comb begin
    enable_d    = ENABLE_I;
    ntrace_d    = ntrace_q;
    mode_d      = mode_q;
    slot_d      = slot_q;
    pack_d      = pack_q;
    data_d      = data_q;
    store_d     = 1'b0;
    trg_event_d = trg_event_q;
    event_pos_d = event_pos_q;
    overflow_d  = overflow_q;
    if (rise_s) begin
      ntrace_d = ntrace_in_s;
      mode_d   = MODE_I;
    end else begin
      ntrace_d = ntrace_q;
      mode_d   = mode_q;
    end
    if (arm_s) begin
      slot_d      = {SLOT_W{1'b0}};
      pack_d      = {TRB_WIDTH{1'b0}};
      trg_event_d = 1'b0;
      event_pos_d = {LOG2W{1'b0}};
      overflow_d  = 1'b0;
    end else if (!ENABLE_I) begin
      // Disabling mid-word throws away the partial word
      slot_d = {SLOT_W{1'b0}};
      pack_d = {TRB_WIDTH{1'b0}};
    end else if (sample_s) begin
      pack_d = word_s;
      if (last_s) begin
        slot_d = {SLOT_W{1'b0}};
        if (STORE_PERM_I) begin
          data_d  = word_s;
          store_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        slot_d = slot_q + {{(SLOT_W-1){1'b0}}, 1'b1};
      end
      if ((state_q == ST_ARMED) && TRG_I && !mode_q) begin
        trg_event_d = 1'b1;
        event_pos_d = LOG2W'(off_s);
      end else begin
        trg_event_d = trg_event_q;
      end
    end else begin
      slot_d = slot_q;
    end
  end

  // State register
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      enable_q    <= 1'b0;
      ntrace_q    <= {TRB_NTRACE_BITS{1'b0}};
      mode_q      <= 1'b0;
      slot_q      <= {SLOT_W{1'b0}};
      pack_q      <= {TRB_WIDTH{1'b0}};
      data_q      <= {TRB_WIDTH{1'b0}};
      store_q     <= 1'b0;
      trg_event_q <= 1'b0;
      event_pos_q <= {LOG2W{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      enable_q    <= enable_d;
      ntrace_q    <= ntrace_d;
      mode_q      <= mode_d;
      slot_q      <= slot_d;
      pack_q      <= pack_d;
      data_q      <= data_d;
      store_q     <= store_d;
      trg_event_q <= trg_event_d;
      event_pos_q <= event_pos_d;
      overflow_q  <= overflow_d;
    end
  end

  assign DATA_O      = data_q;
  assign STORE_O     = store_q;
  assign TRG_EVENT_O = trg_event_q;
  assign EVENT_POS_O = event_pos_q;
  assign OVERFLOW_O  = overflow_q;

endmodule
